regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the in-order pipeline, replacing the fixed 2R/1W file.
//  Adds write-to-read bypass, per-register busy scoreboard for hazard detection, and a sequential clear FSM after reset.
//  Sits between decode (reads, destination allocation) and writeback (writes).
// PARAMETERS
//  XLEN    32  data width per register
//  NREGS   32  number of architectural registers, power of two >= 2; register 0 hardwired to zero
//  NREAD   2   number of read ports
//  NWRITE  1   number of write ports
//  AW      $clog2(NREGS)  localparam, address width
// PORTS
//  clk           in   1             clock; all state updates on posedge
//  rst_n         in   1             reset, synchronous, active-low
//  rd_addr_i     in   NREAD*AW      read addresses
//  rd_data_o     out  NREAD*XLEN    read data, combinational
//  rd_busy_o     out  NREAD         1 = register has an outstanding producer (not bypassable this cycle)
//  wr_en_i       in   NWRITE        write enables
//  wr_addr_i     in   NWRITE*AW     write addresses
//  wr_data_i     in   NWRITE*XLEN   write data
//  alloc_en_i    in   1             decode allocates a destination register (sets busy)
//  alloc_addr_i  in   AW            destination register being allocated
//  init_done_o   out  1             1 = clear sequence finished, file usable
// BEHAVIOUR
//  Reset: rst_n low at posedge -> state INIT, init_ptr=0, all busy bits 0, init_done_o=0. Applies mid-operation too:
//   any clear in progress restarts at 0, pending writes/allocs in that cycle are discarded.
//  INIT: each cycle after reset released writes 0 to reg[init_ptr], init_ptr++. After writing NREGS-1 -> RUN;
//   init_done_o=1 from the following cycle (exactly NREGS cycles after rst_n rises). Writes and allocs ignored;
//   rd_data_o=0, rd_busy_o=0 throughout INIT.
//  RUN: stays in RUN until reset. init_done_o held 1.
//  Read (RUN): rd_data_o[i] = 0 if rd_addr_i[i]==0; else bypass data from the highest-index write port j with
//   wr_en_i[j] && wr_addr_i[j]==rd_addr_i[i]; else reg[rd_addr_i[i]]. Zero-cycle read latency.
//  Write (RUN): at posedge reg[wr_addr_i[j]] <= wr_data_i[j] for each enabled port with address != 0.
//   Writes to register 0 are dropped. Same address on two ports: highest-index port wins (matches bypass priority).
//  Scoreboard: busy[a] set at posedge when alloc_en_i && alloc_addr_i==a && a!=0; cleared at posedge when any
//   enabled write port targets a. Simultaneous alloc and write to same register: alloc wins, busy stays 1
//   (new producer supersedes). busy[0] always 0.
//  rd_busy_o[i] = busy[rd_addr_i[i]] & ~(bypass hit on port i). Alloc affects rd_busy_o from the next cycle only.
//  Re-alloc of an already busy register is legal; busy stays 1 (in-order writeback assumed).
// STRUCTURE
//  regfile_pkg: state enum {INIT, RUN}; default XLEN/NREGS constants.
//  Sub-module regfile_scoreboard: NREGS busy bits with alloc/clear ports and priority rule above;
//   storage, bypass muxes and INIT FSM stay in regfile_mp.
// TESTING
//  Release reset, count cycles -> init_done_o rises exactly 32 cycles later; every read returns 0 before and after.
//  RUN, write x5=0xDEADBEEF, read x5 on port 0 same cycle -> 0xDEADBEEF bypassed; next cycle from storage.
//  Write x0=0x1234, alloc x0 -> read x0 returns 0, rd_busy_o=0.
//  Alloc x7, next cycle read x7 -> busy=1; cycle with wr x7=0x55 -> data 0x55, busy=0; alloc+wr x7 same cycle -> busy=1 next.
//  NWRITE=2: both ports write x3 (0xA, 0xB) -> read returns 0xB same cycle and after.
//  Assert rst_n low mid-INIT (ptr=10) and in RUN with x9 busy -> init restarts, done after 32 cycles, all busy 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
//   - regfile_state_e : clear-sequence FSM states
//   - XLEN_DEFAULT / NREGS_DEFAULT : default data width and register count
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } regfile_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for hazard detection.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (clears all busy bits)
//   i_alloc_en     set busy for i_alloc_addr at posedge (ignored for register 0)
//   i_alloc_addr   destination register being allocated
//   i_wr_en        per-write-port enables; an enabled write clears busy of its target
//   i_wr_addr      per-write-port addresses, flat NWRITE*AW
//   o_busy         registered busy bits, bit 0 always 0
module regfile_scoreboard #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NWRITE = 1,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_alloc_en,
    input  logic [AW-1:0]        i_alloc_addr,
    input  logic [NWRITE-1:0]    i_wr_en,
    input  logic [NWRITE*AW-1:0] i_wr_addr,
    output logic [NREGS-1:0]     o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_d;

    // Clears first, then alloc: a new producer supersedes a completing one.
    always_comb begin
        w_busy_d = r_busy;
        for (int j = 0; j < NWRITE; j++) begin
            if (i_wr_en[j]) begin
                w_busy_d[i_wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (i_alloc_en) begin
            w_busy_d[i_alloc_addr] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with write-to-read bypass,
// busy scoreboard and a sequential clear after reset.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   rd_addr_i      NREAD read addresses (flat)
//   rd_data_o      NREAD read data, combinational (bypass > storage, x0 = 0)
//   rd_busy_o      per read port: register has an outstanding, non-bypassable producer
//   wr_en_i        NWRITE write enables
//   wr_addr_i      NWRITE write addresses (flat)
//   wr_data_i      NWRITE write data (flat)
//   alloc_en_i     decode allocates destination alloc_addr_i (sets busy)
//   alloc_addr_i   destination register
//   init_done_o    clear sequence finished, file usable
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEFAULT,
    parameter  int unsigned NREGS  = NREGS_DEFAULT,
    parameter  int unsigned NREAD  = 2,
    parameter  int unsigned NWRITE = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    rd_addr_i,
    output logic [NREAD*XLEN-1:0]  rd_data_o,
    output logic [NREAD-1:0]       rd_busy_o,
    input  logic [NWRITE-1:0]      wr_en_i,
    input  logic [NWRITE*AW-1:0]   wr_addr_i,
    input  logic [NWRITE*XLEN-1:0] wr_data_i,
    input  logic                   alloc_en_i,
    input  logic [AW-1:0]          alloc_addr_i,
    output logic                   init_done_o
);

    regfile_state_e r_state, w_state_d;
    logic [AW-1:0]  r_init_ptr, w_init_ptr_d;
    logic           w_init_we;
    logic           w_run;

    logic [XLEN-1:0]   r_mem [NREGS];
    logic [NWRITE-1:0] w_wr_en;
    logic              w_alloc_en;
    logic [NREGS-1:0]  w_busy;
    logic [NREAD-1:0]  w_hit;
    logic [XLEN-1:0]   w_byp_data [NREAD];

    // ---------------------------------------------------------------
    // Clear-sequence FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StInit;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_d;
            r_init_ptr <= w_init_ptr_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_init_ptr_d = r_init_ptr;
        w_init_we    = 1'b0;
        unique case (r_state)
            StInit: begin
                w_init_we    = 1'b1;
                w_init_ptr_d = r_init_ptr + 1'b1;
                if (r_init_ptr == AW'(NREGS - 1)) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_state_d = StRun;
            end
        endcase
    end

    assign w_run       = (r_state == StRun);
    assign init_done_o = w_run;

    // Writes and allocs only take effect once the file is usable.
    assign w_wr_en    = wr_en_i & {NWRITE{w_run}};
    assign w_alloc_en = alloc_en_i & w_run & (alloc_addr_i != '0);

    // ---------------------------------------------------------------
    // Storage: no reset; the clear sequence zeroes it. Ascending port
    // order makes the highest-index port win on an address collision.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_init_we) begin
                r_mem[r_init_ptr] <= '0;
            end else begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (w_wr_en[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
                        r_mem[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------
    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alloc_en   (w_alloc_en),
        .i_alloc_addr (alloc_addr_i),
        .i_wr_en      (w_wr_en),
        .i_wr_addr    (wr_addr_i),
        .o_busy       (w_busy)
    );

    // ---------------------------------------------------------------
    // Read ports with bypass; highest-index matching write port wins.
    // ---------------------------------------------------------------
    always_comb begin
        w_hit     = '0;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NREAD; i++) begin
            w_byp_data[i] = '0;
            for (int j = 0; j < NWRITE; j++) begin
                if (w_wr_en[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i[i*AW +: AW])) begin
                    w_hit[i]      = 1'b1;
                    w_byp_data[i] = wr_data_i[j*XLEN +: XLEN];
                end
            end
            if (w_run && (rd_addr_i[i*AW +: AW] != '0)) begin
                rd_data_o[i*XLEN +: XLEN] = w_hit[i] ? w_byp_data[i]
                                                     : r_mem[rd_addr_i[i*AW +: AW]];
                rd_busy_o[i] = w_busy[rd_addr_i[i*AW +: AW]] & ~w_hit[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read ports, 2 write ports, 32 x 32-bit).
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        init_done;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .XLEN   (32),
        .NREGS  (32),
        .NREAD  (2),
        .NWRITE (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .alloc_en_i   (alloc_en),
        .alloc_addr_i (alloc_addr),
        .init_done_o  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        rd_addr    = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    // Advance one clock; leave inputs idle at the following negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    // Called at a negedge with rst_n just raised: counts cycles to init_done,
    // reads must stay 0/not-busy, and a write/alloc issued mid-clear is ignored.
    task automatic run_init(input string tag);
        int done_at;
        int nz;
        done_at = 0;
        nz      = 0;
        for (int c = 1; c <= 40; c++) begin
            idle();
            if (c == 20) begin
                wr(0, 5'd1, 32'h0000_FFFF);
                alloc_en   = 1'b1;
                alloc_addr = 5'd2;
            end
            rd(0, 5'd1);
            rd(1, 5'd5);
            #1;
            if (rd_data !== 64'd0 || rd_busy !== 2'b00) nz++;
            @(posedge clk);
            @(negedge clk);
            if (init_done === 1'b1 && done_at == 0) done_at = c;
            if (done_at != 0) break;
        end
        idle();
        chk({tag, "_done_latency"}, 32'(done_at), 32'd32);
        chk({tag, "_reads_zero_in_init"}, 32'(nz), 32'd0);
        rd(0, 5'd1);
        rd(1, 5'd2);
        #1;
        chk({tag, "_x1_cleared"}, rd_data[31:0], 32'd0);
        chk({tag, "_x2_not_busy"}, 32'(rd_busy[1]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_done_low", 32'(init_done), 32'd0);
        rd(0, 5'd5);
        #1;
        chk("reset_read_zero", rd_data[31:0], 32'd0);

        // Release and run the clear sequence.
        rst_n = 1'b1;
        run_init("init1");

        // Same-cycle bypass, then storage.
        idle();
        wr(0, 5'd5, 32'hDEAD_BEEF);
        rd(0, 5'd5);
        #1;
        chk("byp_x5_data", rd_data[31:0], 32'hDEAD_BEEF);
        chk("byp_x5_busy", 32'(rd_busy[0]), 32'd0);
        cyc();
        rd(0, 5'd5);
        #1;
        chk("store_x5_data", rd_data[31:0], 32'hDEAD_BEEF);

        // Register 0 stays zero and never busy.
        wr(0, 5'd0, 32'h0000_1234);
        alloc_en   = 1'b1;
        alloc_addr = 5'd0;
        rd(0, 5'd0);
        #1;
        chk("x0_same_cycle", rd_data[31:0], 32'd0);
        cyc();
        rd(0, 5'd0);
        #1;
        chk("x0_data", rd_data[31:0], 32'd0);
        chk("x0_busy", 32'(rd_busy[0]), 32'd0);

        // Scoreboard on x7.
        alloc_en   = 1'b1;
        alloc_addr = 5'd7;
        rd(0, 5'd7);
        #1;
        chk("x7_alloc_cycle_busy", 32'(rd_busy[0]), 32'd0);
        cyc();
        rd(0, 5'd7);
        rd(1, 5'd7);
        #1;
        chk("x7_busy_next", 32'(rd_busy), 32'd3);
        wr(0, 5'd7, 32'h55);
        #1;
        chk("x7_wb_byp_data", rd_data[31:0], 32'h55);
        chk("x7_wb_byp_busy", 32'(rd_busy), 32'd0);
        cyc();
        rd(0, 5'd7);
        #1;
        chk("x7_after_wb_busy", 32'(rd_busy[0]), 32'd0);
        chk("x7_after_wb_data", rd_data[31:0], 32'h55);
        wr(0, 5'd7, 32'h66);
        alloc_en   = 1'b1;
        alloc_addr = 5'd7;
        cyc();
        rd(0, 5'd7);
        #1;
        chk("x7_alloc_wins_busy", 32'(rd_busy[0]), 32'd1);
        chk("x7_alloc_wins_data", rd_data[31:0], 32'h66);
        wr(1, 5'd7, 32'h77);
        cyc();
        rd(0, 5'd7);
        #1;
        chk("x7_port1_clears", 32'(rd_busy[0]), 32'd0);
        chk("x7_port1_data", rd_data[31:0], 32'h77);

        // Two write ports to the same register: port 1 wins.
        wr(0, 5'd3, 32'hA);
        wr(1, 5'd3, 32'hB);
        rd(0, 5'd3);
        rd(1, 5'd3);
        #1;
        chk("dual_wr_byp_p0", rd_data[31:0], 32'hB);
        chk("dual_wr_byp_p1", rd_data[63:32], 32'hB);
        cyc();
        rd(0, 5'd3);
        #1;
        chk("dual_wr_store", rd_data[31:0], 32'hB);

        // Reset in RUN with x9 busy, pending write/alloc discarded.
        alloc_en   = 1'b1;
        alloc_addr = 5'd9;
        cyc();
        rd(1, 5'd9);
        #1;
        chk("x9_busy_before_rst", 32'(rd_busy[1]), 32'd1);
        rst_n      = 1'b0;
        alloc_en   = 1'b1;
        alloc_addr = 5'd10;
        wr(0, 5'd3, 32'hCC);
        cyc();
        chk("run_rst_done_low", 32'(init_done), 32'd0);
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("mid_init_done_low", 32'(init_done), 32'd0);

        // Reset again mid-clear: the sequence must restart from 0.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        run_init("init2");
        rd(0, 5'd9);
        rd(1, 5'd10);
        #1;
        chk("post_rst_busy_clear", 32'(rd_busy), 32'd0);
        rd(0, 5'd3);
        rd(1, 5'd5);
        #1;
        chk("post_rst_x3_zero", rd_data[31:0], 32'd0);
        chk("post_rst_x5_zero", rd_data[63:32], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
